// File: rtl/postcard_pkg.sv
// Shared definitions for the POST-code display path: FSM states and ms-to-cycle conversion.
package postcard_pkg;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_REPLAY = 1'b1
  } state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/postcode_history_sequencer_if.sv
// POST-code source / display-side signals of the history sequencer.
interface postcode_history_sequencer_if #(
  parameter int unsigned DEPTH = 16
) ();

  logic                   code_valid;
  logic [7:0]             code;
  logic                   replay_n;
  logic [7:0]             display_code;
  logic                   display_dp;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  modport master (
    output code_valid, code, replay_n,
    input  display_code, display_dp, count, overflow
  );

  modport slave (
    input  code_valid, code, replay_n,
    output display_code, display_dp, count, overflow
  );

endinterface

// File: rtl/thcattus_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debounce, one-cycle press pulse on 1->0.
module thcattus_debounce
  import postcard_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 25_000_000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned DB_CYC = ms_to_cycles(CLOCK_FREQ, DEBOUNCE_MS);
  localparam int unsigned CNTW   = $clog2(DB_CYC + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNTW'(DB_CYC - 1)) level_d = sync2_q;
      else                             cnt_d   = cnt_q + CNTW'(1);
    end
    press = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/postcode_history_sequencer.sv
// Ring buffer of recent POST codes with live display and button-triggered oldest-to-newest replay.
module postcode_history_sequencer
  import postcard_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ  = 25_000_000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned STEP_MS     = 500,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter bit          DEDUP       = 1'b1
) (
  input logic clk,
  input logic reset_n,
  postcode_history_sequencer_if.slave bus
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned CW       = PW + 1;
  localparam int unsigned STEP_CYC = ms_to_cycles(CLOCK_FREQ, STEP_MS);
  localparam int unsigned SW       = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [PW-1:0] ONE_P  = PW'(1);

  logic [7:0]    mem [DEPTH];
  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, end_ptr_q, end_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] step_q, step_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    disp_q, disp_d;
  logic          dp_q, dp_d;
  logic          press, wr_en;
  logic [7:0]    newest, newest_next, rd_view;

  thcattus_debounce #(
    .CLOCK_FREQ  (CLOCK_FREQ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) u_debounce (
    .clk   (clk),
    .rst_n (reset_n),
    .btn_n (bus.replay_n),
    .press (press)
  );

  always_comb begin
    newest      = mem[wr_ptr_q - ONE_P];
    wr_en       = bus.code_valid && !(DEDUP && (count_q != '0) && (bus.code == newest));
    newest_next = wr_en ? bus.code : newest;
    wr_ptr_d    = wr_en ? wr_ptr_q + ONE_P : wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    if (wr_en) begin
      if (count_q == CW'(DEPTH)) overflow_d = 1'b1;
      else                       count_d    = count_q + CW'(1);
    end

    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    end_ptr_d = end_ptr_q;
    step_d    = step_q;
    case (state_q)
      ST_LIVE: begin
        // Snapshot includes a write landing in the same cycle as the press.
        if (press && (count_d != '0)) begin
          state_d   = ST_REPLAY;
          end_ptr_d = wr_ptr_d;
          rd_ptr_d  = wr_ptr_d - count_d[PW-1:0];
          step_d    = '0;
        end
      end
      ST_REPLAY: begin
        if (press) begin
          state_d = ST_LIVE;
        end else if (step_q == SW'(STEP_CYC - 1)) begin
          step_d = '0;
          if (rd_ptr_q + ONE_P == end_ptr_q) state_d  = ST_LIVE;
          else                               rd_ptr_d = rd_ptr_q + ONE_P;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
    endcase

    // Forward a same-cycle write so an overwritten slot shows its new contents immediately.
    rd_view = (wr_en && (wr_ptr_q == rd_ptr_d)) ? bus.code : mem[rd_ptr_d];
    dp_d    = (state_d == ST_REPLAY);
    if (state_d == ST_REPLAY)                 disp_d = rd_view;
    else if (wr_en || (state_q == ST_REPLAY)) disp_d = newest_next;
    else                                      disp_d = disp_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_LIVE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      end_ptr_q  <= '0;
      count_q    <= '0;
      step_q     <= '0;
      overflow_q <= 1'b0;
      disp_q     <= 8'h00;
      dp_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      end_ptr_q  <= end_ptr_d;
      count_q    <= count_d;
      step_q     <= step_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.display_code = disp_q;
  assign bus.display_dp   = dp_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_postcode_history_sequencer.sv
// Directed + randomized bench for postcode_history_sequencer against a queue-based history model.
module tb_postcode_history_sequencer;

  localparam int STEP  = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       replay_n = 1'b1;

  int checks = 0;
  int errors = 0;

  // Model: h0 is the DEDUP=1 history, h1 the DEDUP=0 history, oldest first.
  logic [7:0] h0[$];
  logic [7:0] h1[$];
  logic [7:0] snap[$];
  bit         ov0, ov1;

  postcode_history_sequencer_if #(.DEPTH(DEPTH)) bus0 ();
  postcode_history_sequencer_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus0.code_valid = code_valid;
  assign bus0.code       = code;
  assign bus0.replay_n   = replay_n;
  assign bus1.code_valid = code_valid;
  assign bus1.code       = code;
  assign bus1.replay_n   = replay_n;

  postcode_history_sequencer #(
    .CLOCK_FREQ(10_000), .DEPTH(DEPTH), .STEP_MS(1), .DEBOUNCE_MS(1), .DEDUP(1'b1)
  ) dut (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));

  postcode_history_sequencer #(
    .CLOCK_FREQ(10_000), .DEPTH(DEPTH), .STEP_MS(1), .DEBOUNCE_MS(1), .DEDUP(1'b0)
  ) dut_nd (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] newest0();
    return (h0.size() > 0) ? h0[$] : 8'h00;
  endfunction

  task automatic model_reset();
    h0.delete();
    h1.delete();
    ov0 = 1'b0;
    ov1 = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] c);
    if (!(h0.size() > 0 && h0[$] == c)) begin
      h0.push_back(c);
      if (h0.size() > DEPTH) begin void'(h0.pop_front()); ov0 = 1'b1; end
    end
    h1.push_back(c);
    if (h1.size() > DEPTH) begin void'(h1.pop_front()); ov1 = 1'b1; end
  endtask

  task automatic strobe(input logic [7:0] c);
    code       = c;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    model_write(c);
  endtask

  task automatic check_live(input string tag);
    chk({tag, "_disp"},  32'(bus0.display_code), 32'(newest0()));
    chk({tag, "_dp"},    32'(bus0.display_dp),   32'd0);
    chk({tag, "_cnt"},   32'(bus0.count),        32'(h0.size()));
    chk({tag, "_ovf"},   32'(bus0.overflow),     32'(ov0));
    chk({tag, "_cnt_nd"}, 32'(bus1.count),       32'(h1.size()));
    chk({tag, "_ovf_nd"}, 32'(bus1.overflow),    32'(ov1));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_idle_dp"},   32'(bus0.display_dp),   32'd0);
      chk({tag, "_idle_disp"}, 32'(bus0.display_code), 32'(newest0()));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    model_reset();
  endtask

  // Hold the button low from now; replay must start exactly 12 edges later if history is non-empty.
  task automatic press_enter(input string tag);
    bit exp_enter;
    exp_enter = (h0.size() > 0);
    replay_n  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk({tag, "_entry_dp"}, 32'(bus0.display_dp), 32'(exp_enter && k == 12));
    end
    snap = h0;
  endtask

  task automatic run_replay(input string tag, input int abort_at, input int inject_at,
                            input logic [7:0] inj);
    int n;
    n = snap.size();
    for (int k = 0; k <= n * STEP; k++) begin
      if (k == n * STEP || k == abort_at) begin
        chk({tag, "_exit_dp"},   32'(bus0.display_dp),   32'd0);
        chk({tag, "_exit_disp"}, 32'(bus0.display_code), 32'(newest0()));
        break;
      end
      chk({tag, "_rp_dp"},   32'(bus0.display_dp),   32'd1);
      chk({tag, "_rp_disp"}, 32'(bus0.display_code), 32'(snap[k / STEP]));
      if (k == 0) replay_n = 1'b1;
      if (abort_at >= 12 && k == abort_at - 12) replay_n = 1'b0;
      if (k == inject_at) strobe(inj);
      else                step();
    end
    replay_n = 1'b1;
  endtask

  initial begin
    logic [7:0] c;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_disp", 32'(bus0.display_code), 32'h00);
    chk("rst_dp",   32'(bus0.display_dp),   32'd0);
    chk("rst_cnt",  32'(bus0.count),        32'd0);
    chk("rst_ovf",  32'(bus0.overflow),     32'd0);
    step();
    step();
    reset_n = 1'b1;
    model_reset();
    idle("start", 15);

    // Live update
    strobe(8'h19); check_live("live19");
    strobe(8'hA2); check_live("liveA2");
    chk("live_cnt2", 32'(bus0.count), 32'd2);

    // Dedup vs no-dedup
    do_reset();
    for (int i = 0; i < 3; i++) begin strobe(8'h55); check_live("dedup55"); end
    chk("dedup_cnt",    32'(bus0.count), 32'd1);
    chk("nodedup_cnt",  32'(bus1.count), 32'd3);

    // Overflow then full replay
    do_reset();
    idle("pre_ovf", 15);
    for (int i = 1; i <= 6; i++) begin strobe(8'(i)); check_live("ovf"); end
    chk("ovf_flag", 32'(bus0.overflow), 32'd1);
    idle("ovf_gap", 5);
    press_enter("ovf");
    run_replay("ovf", -1, -1, 8'h00);
    idle("ovf_post", 20);

    // Bounce: 14 three-cycle segments alternating low/high, then a steady hold
    for (int s = 0; s < 14; s++) begin
      replay_n = (s % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 3; j++) begin
        step();
        chk("bounce_dp", 32'(bus0.display_dp), 32'd0);
      end
    end
    press_enter("bounce");
    run_replay("bounce_e0", -1, 13, 8'hE0);
    chk("e0_after_exit", 32'(bus0.display_code), 32'hE0);
    idle("bounce_post", 30);

    // Abort mid-replay
    press_enter("abort");
    run_replay("abort", 25, -1, 8'h00);
    idle("abort_post", 20);
    check_live("abort_live");

    // Empty press, then reset in the middle of a replay
    do_reset();
    idle("empty_pre", 15);
    press_enter("empty");
    chk("empty_disp", 32'(bus0.display_code), 32'h00);
    replay_n = 1'b1;
    idle("empty_post", 20);
    strobe(8'hA1); strobe(8'hB2); strobe(8'hC3);
    check_live("prerst");
    idle("prerst_gap", 5);
    press_enter("midrst");
    replay_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_disp",   32'(bus0.display_code), 32'h00);
    chk("async_dp",     32'(bus0.display_dp),   32'd0);
    chk("async_cnt",    32'(bus0.count),        32'd0);
    chk("async_ovf",    32'(bus0.overflow),     32'd0);
    chk("async_cnt_nd", 32'(bus1.count),        32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    step();
    check_live("after_rst");
    idle("after_rst", 15);

    // Randomized bursts, each followed by a full replay checked against the model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          if (h0.size() > 0 && $urandom_range(0, 2) == 0) c = newest0();
          else                                            c = 8'($urandom);
          strobe(c);
        end else begin
          step();
        end
        check_live("rnd");
      end
      press_enter("rnd");
      if (snap.size() > 0) run_replay("rnd", -1, -1, 8'h00);
      else                 replay_n = 1'b1;
      idle("rnd_post", 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
